// File: rtl/clock_div_prog_multi_if.sv
// Control/status bundle for clock_div_prog_multi.
//   ENABLE   : per-channel run enable
//   SYNC     : one-cycle pulse, restarts all enabled channels in phase
//   DIV_WE   : divisor write strobe
//   DIV_SEL  : channel addressed by the write
//   DIV_DATA : new divisor value
//   CLK_OUT  : divided clocks (registered)
//   TICK     : one-cycle strobe on each CLK_OUT rise
// master = controller/consumer side, slave = divider side.
interface clock_div_prog_multi_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 17,
  parameter int SEL_W  = 2
);
  logic [NUM_CH-1:0] ENABLE;
  logic              SYNC;
  logic              DIV_WE;
  logic [SEL_W-1:0]  DIV_SEL;
  logic [CNT_W-1:0]  DIV_DATA;
  logic [NUM_CH-1:0] CLK_OUT;
  logic [NUM_CH-1:0] TICK;

  modport master (output ENABLE, SYNC, DIV_WE, DIV_SEL, DIV_DATA,
                  input  CLK_OUT, TICK);
  modport slave  (input  ENABLE, SYNC, DIV_WE, DIV_SEL, DIV_DATA,
                  output CLK_OUT, TICK);
endinterface

// File: rtl/clock_div_prog_multi.sv
// Runtime-programmable multi-channel clock divider.
// Each channel divides CLK_IN by its active divisor D = max(A,2), high for
// ceil(D/2) cycles. New divisors are staged in a pending register and only
// adopted at a period restart, so outputs never produce runt pulses.
// Ports:
//   CLK_IN  : source clock, rising edge
//   RESET_N : asynchronous active-low reset
//   bus     : control/status bundle (slave modport)

// One divider lane.
//   i_en/i_sync : lane enable and shared phase-align pulse
//   i_we/i_data : already-decoded divisor write for this lane
//   o_clk/o_tick: divided clock and rise strobe
module clock_div_prog_multi_ch #(
  parameter int CNT_W       = 17,
  parameter int DEFAULT_DIV = 26
) (
  input  logic             CLK_IN,
  input  logic             RESET_N,
  input  logic             i_en,
  input  logic             i_sync,
  input  logic             i_we,
  input  logic [CNT_W-1:0] i_data,
  output logic             o_clk,
  output logic             o_tick
);
  localparam logic [CNT_W-1:0] DEF = CNT_W'(DEFAULT_DIV);

  logic [CNT_W-1:0] r_pend, r_act, r_cnt;
  logic             r_run, r_clk, r_tick;

  logic [CNT_W-1:0] w_d;
  logic [CNT_W:0]   w_h;
  logic [CNT_W-1:0] w_cnt_nx;
  logic             w_last, w_restart;

  // Divisors 0 and 1 behave as 2.
  assign w_d       = (r_act < CNT_W'(2)) ? CNT_W'(2) : r_act;
  // One extra bit so ceil(D/2) is exact even for D = 2^CNT_W-1.
  assign w_h       = ({1'b0, w_d} + (CNT_W+1)'(1)) >> 1;
  assign w_last    = (r_cnt == w_d - CNT_W'(1));
  // SYNC coinciding with the last count is still just one restart.
  assign w_restart = i_en & (~r_run | i_sync | w_last);
  assign w_cnt_nx  = r_cnt + CNT_W'(1);

  always_ff @(posedge CLK_IN or negedge RESET_N) begin
    if (!RESET_N) begin
      r_pend <= DEF;
      r_act  <= DEF;
      r_cnt  <= '0;
      r_run  <= 1'b0;
      r_clk  <= 1'b0;
      r_tick <= 1'b0;
    end else begin
      if (i_we) r_pend <= i_data;
      if (!i_en) begin
        r_cnt  <= '0;
        r_run  <= 1'b0;
        r_clk  <= 1'b0;
        r_tick <= 1'b0;
      end else if (w_restart) begin
        // r_pend here is the pre-edge value; a same-cycle write waits a period.
        r_cnt  <= '0;
        r_act  <= r_pend;
        r_run  <= 1'b1;
        r_clk  <= 1'b1;
        r_tick <= 1'b1;
      end else begin
        r_cnt  <= w_cnt_nx;
        r_clk  <= ({1'b0, w_cnt_nx} < w_h);
        r_tick <= 1'b0;
      end
    end
  end

  assign o_clk  = r_clk;
  assign o_tick = r_tick;
endmodule

module clock_div_prog_multi #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 17,
  parameter int SEL_W       = 2,
  parameter int DEFAULT_DIV = 26
) (
  input  logic CLK_IN,
  input  logic RESET_N,
  clock_div_prog_multi_if.slave bus
);
  logic [NUM_CH-1:0] w_clk, w_tick, w_we;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic [SEL_W-1:0] CH_IDX = SEL_W'(i);
    // Selects beyond NUM_CH-1 match no lane and are dropped.
    assign w_we[i] = bus.DIV_WE && (bus.DIV_SEL == CH_IDX);

    clock_div_prog_multi_ch #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .CLK_IN  (CLK_IN),
      .RESET_N (RESET_N),
      .i_en    (bus.ENABLE[i]),
      .i_sync  (bus.SYNC),
      .i_we    (w_we[i]),
      .i_data  (bus.DIV_DATA),
      .o_clk   (w_clk[i]),
      .o_tick  (w_tick[i])
    );
  end

  assign bus.CLK_OUT = w_clk;
  assign bus.TICK    = w_tick;
endmodule

// File: doc/clock_div_prog_multi.md
Name: clock_div_prog_multi

Overview:
Parametrised, runtime-programmable multi-channel clock divider and successor to the fixed 26 MHz-to-1 MHz divider. It produces NUM_CH independent divided clocks from one source clock, each with a one-cycle tick strobe. Divisors can be even or odd and are reloaded glitch-free at period boundaries. Channels can be individually enabled and phase-aligned by a common SYNC. It sits at the top of the avionics clock tree and feeds sensor, UART and timestamp logic.

Parameters:
NUM_CH, 4, number of output channels (1..16)
CNT_W, 17, width of divisor and of each period counter
SEL_W, 2, width of channel select; must satisfy 2^SEL_W >= NUM_CH
DEFAULT_DIV, 26, divisor loaded into every channel at reset

Ports:
CLK_IN  input  1  source clock; all logic is on its rising edge
RESET_N  input  1  asynchronous, active-low reset
ENABLE  input  NUM_CH  per-channel run enable
SYNC  input  1  single-cycle pulse; restarts all enabled channels in phase
DIV_WE  input  1  divisor write strobe
DIV_SEL  input  SEL_W  channel addressed by the write
DIV_DATA  input  CNT_W  new divisor value
CLK_OUT  output  NUM_CH  divided clocks, registered
TICK  output  NUM_CH  one-cycle pulse on the cycle each CLK_OUT rises

Behaviour:
- Reset (RESET_N low, asynchronous) takes effect immediately:
  - CLK_OUT = 0 and TICK = 0.
  - Every counter = 0 and every running flag = 0.
  - Every pending and active divisor = DEFAULT_DIV.
- Per-channel state: pending divisor P, active divisor A, counter cnt (0..A-1), running flag.
- Effective divisor: D = max(A, 2); values 0 and 1 are clamped to 2. High time H = ceil(D/2), low time D-H.
- Write: on a DIV_WE edge with DIV_SEL < NUM_CH, P[DIV_SEL] <= DIV_DATA. Writes with DIV_SEL >= NUM_CH are ignored. P never affects the current period.
- Each edge, per channel, with flag restart = (ENABLE & !running) | (ENABLE & SYNC) | (ENABLE & cnt == D-1):
  - ENABLE=0: cnt<=0, running<=0, CLK_OUT<=0, TICK<=0. Stopping is immediate; no period completion.
  - restart: cnt<=0, A<=P (value held before this edge), running<=1, CLK_OUT<=1, TICK<=1.
  - otherwise: cnt<=cnt+1, CLK_OUT<=(cnt+1 < H), TICK<=0.
- Latency:
  - CLK_OUT first rises 1 cycle after ENABLE is sampled high.
  - Period is exactly D CLK_IN cycles, high for H and low for D-H. Duty is 50% for even D; odd D gives one extra high cycle.
- Timing of a new divisor: a write takes effect at the next restart, never mid-period, so no runt pulses. A write in the same cycle as a restart lands in P and is used at the following restart.
- SYNC restarts all enabled channels on the same edge, aligning their rising edges. Disabled channels ignore SYNC.
- SYNC while already at cnt == D-1 counts as a single restart; no double tick.
- Counter arithmetic is unsigned CNT_W bits. Because cnt < D <= 2^CNT_W-1, it never wraps.
- Channels are fully independent except for the shared SYNC and write bus.
- Reset mid-period: outputs drop asynchronously. After RESET_N deasserts, enabled channels start on the first edge as a fresh restart with DEFAULT_DIV.

Test Plan:
- Reset release, ENABLE=4'b0001, defaults -> CLK_OUT[0] rises 1 cycle after enable, 13 high / 13 low repeating; TICK[0] pulses every 26 cycles; other channels stay 0.
- Ch0 running at 26; at cnt=5 write DIV_SEL=0, DIV_DATA=5 -> current period completes at 26; afterwards 3 high / 2 low, TICK every 5.
- Write divisors 0, 1 and 2 to ch1..ch3 and enable -> all three show period 2, 1 high / 1 low.
- Ch0 divisor 4 and ch1 divisor 6, both running out of phase; pulse SYNC -> both rise on the next edge, and rising edges coincide every 12 cycles.
- Deassert ENABLE[0] while CLK_OUT[0] is high -> low on the next edge; re-enable -> rises after 1 cycle with TICK, full first period.
- Assert RESET_N low mid-high-phase, asynchronously -> CLK_OUT/TICK go 0 without a clock edge; previously written divisors revert to 26.
